// File: rtl/stream_sorter.sv
// stream_sorter -- collects DEPTH unsigned words, sorts them with an
// odd-even transposition network (one pass per cycle, DEPTH passes), then
// streams the sorted block out with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a word
//   in_data    unsigned input word (WIDTH bits)
//   in_ready   block can take a word (IDLE/LOAD)
//   out_valid  out_data holds a sorted word (OUT only)
//   out_data   sorted output word (WIDTH bits)
//   out_last   final word of a block
//   out_ready  downstream accepts out_data
//   desc       order select, present only with STREAM_SORTER_DESC_EN
//
// Optional feature macro: STREAM_SORTER_DESC_EN adds the desc port; desc is
// sampled on the first accepted beat of each block and selects descending
// order for that block. Without it the block sorts ascending only.
module stream_sorter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
`ifdef STREAM_SORTER_DESC_EN
  ,
  input  logic             desc
`endif
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [IW-1:0]    cnt_q;
  logic [IW-1:0]    pass_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] buf_q    [DEPTH];
  logic [WIDTH-1:0] sorted_d [DEPTH];
  logic [DEPTH-2:0] swap_s;
  logic             desc_s;

`ifdef STREAM_SORTER_DESC_EN
  logic desc_q;
  assign desc_s = desc_q;
`else
  assign desc_s = 1'b0;
`endif

  // Equal words never swap, so duplicates keep their relative order.
  function automatic logic need_swap(input logic [WIDTH-1:0] lo,
                                     input logic [WIDTH-1:0] hi,
                                     input logic             dsc);
    if (dsc) begin
      need_swap = (lo < hi);
    end else begin
      need_swap = (lo > hi);
    end
  endfunction

  // Even passes pair (0,1),(2,3)...; odd passes pair (1,2),(3,4)...
  // A pair starting at slot g is active when its parity matches pass_q[0].
  for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cmp
    localparam logic PAR = 1'(g % 2);
    assign swap_s[g] = (pass_q[0] == PAR) && need_swap(buf_q[g], buf_q[g+1], desc_s);
  end

  // Each slot takes its partner's word when its pair swaps; pairs in one pass
  // are disjoint, so at most one of the two neighbour flags is set.
  for (genvar g = 0; g < DEPTH; g++) begin : g_net
    if (g == 0) begin : g_first
      assign sorted_d[g] = swap_s[0] ? buf_q[1] : buf_q[0];
    end else if (g == DEPTH - 1) begin : g_final
      assign sorted_d[g] = swap_s[g-1] ? buf_q[g-1] : buf_q[g];
    end else begin : g_mid
      assign sorted_d[g] = swap_s[g]   ? buf_q[g+1] :
                           swap_s[g-1] ? buf_q[g-1] : buf_q[g];
    end
  end

  // Control FSM, buffer storage and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
      pass_q      <= '0;
      idx_q       <= '0;
`ifdef STREAM_SORTER_DESC_EN
      desc_q      <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready is 0 during reset, so it rises on the first clock after.
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            buf_q[0] <= in_data;
            cnt_q    <= IW'(1);
            state_q  <= LOAD;
`ifdef STREAM_SORTER_DESC_EN
            desc_q   <= desc;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            buf_q[cnt_q] <= in_data;
            if (cnt_q == IW'(DEPTH - 1)) begin
              state_q    <= SORT;
              in_ready_q <= 1'b0;
              cnt_q      <= '0;
              pass_q     <= '0;
            end else begin
              cnt_q <= cnt_q + IW'(1);
            end
          end
        end
        SORT: begin
          for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= sorted_d[i];
          end
          if (pass_q == IW'(DEPTH - 1)) begin
            // Present slot 0 of the final network result right away.
            state_q     <= OUT;
            pass_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= sorted_d[0];
            out_last_q  <= 1'b0;
          end else begin
            pass_q <= pass_q + IW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            if (idx_q == IW'(DEPTH - 1)) begin
              state_q     <= IDLE;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              idx_q       <= '0;
            end else begin
              idx_q      <= idx_q + IW'(1);
              out_data_q <= buf_q[idx_q + IW'(1)];
              out_last_q <= ((idx_q + IW'(1)) == IW'(DEPTH - 1));
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_sorter.sv
// tb_stream_sorter -- directed self-checking bench for stream_sorter with
// WIDTH=32, DEPTH=8. Each scenario task drives its stimulus and compares
// observed outputs against hand-computed sorted blocks.
module tb_stream_sorter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  typedef logic [WIDTH-1:0] blk_t [DEPTH];

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
`ifdef STREAM_SORTER_DESC_EN
  logic             desc;
`endif

  int errors;
  int checks;

  stream_sorter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
`ifdef STREAM_SORTER_DESC_EN
    ,
    .desc      (desc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and wait (bounded) until it is accepted.
  task automatic push(input logic [WIDTH-1:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_block(input blk_t v, input int max_gap);
    int g;
    for (int i = 0; i < DEPTH; i++) begin
      push(v[i]);
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (i < DEPTH - 1) begin
        for (int k = 0; k < g; k++) tick();
      end
    end
  endtask

  // Wait for out_valid after the last input edge; checks latency and in_ready=0.
  task automatic wait_sort(input bit junk);
    int cyc;
    cyc = 0;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
    end
    while (out_valid !== 1'b1 && cyc < 50) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL sort_in_ready: in_ready=%b at sort cycle %0d, required 0", in_ready, cyc);
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== DEPTH) begin
      errors++;
      $display("FAIL sort_latency: out_valid rose after %0d cycles, required %0d", cyc, DEPTH);
    end
  endtask

  // Drain n words, optionally with random stalls; checks data, last, stability.
  task automatic collect(input blk_t e, input int n, input bit stall, input bit junk);
    bit r;
    int st;
    for (int j = 0; j < n; j++) begin
      st = 0;
      do begin
        r = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (st >= 6) r = 1'b1;
        out_ready = r;
        checks++;
        if (out_valid !== 1'b1 || out_data !== e[j] || out_last !== (j == DEPTH - 1) ||
            in_ready !== 1'b0) begin
          errors++;
          $display("FAIL out_word%0d: valid=%b data=%h last=%b in_ready=%b, required 1 %h %b 0",
                   j, out_valid, out_data, out_last, in_ready, e[j], (j == DEPTH - 1));
        end
        tick();
        st++;
      end while (!r);
    end
    out_ready = 1'b0;
    if (junk) in_valid = 1'b0;
    if (n == DEPTH) begin
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL block_end: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_data=%h out_last=%b, required all 0",
               tag, in_ready, out_valid, out_data, out_last);
    end
  endtask

  // Assert reset asynchronously mid-cycle, check outputs, then release.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check_reset_outputs(tag);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b, required 1", tag, in_ready);
    end
  endtask

  task automatic test_reset();
    #3;
    check_reset_outputs("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    blk_t v, e;
    v = '{32'd5, 32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd8, 32'd6};
    e = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    push_block(v, 0);
    wait_sort(1'b0);
    collect(e, DEPTH, 1'b0, 1'b0);
  endtask

  task automatic test_unsigned_dups();
    blk_t v, e;
    v = '{32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h1, 32'h4, 32'h4, 32'h4, 32'h0};
    e = '{32'h0, 32'h0, 32'h1, 32'h4, 32'h4, 32'h4, 32'h8000_0000, 32'hFFFF_FFFF};
    push_block(v, 0);
    wait_sort(1'b0);
    collect(e, DEPTH, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    blk_t up, dn;
    up = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    dn = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    push_block(up, 0);
    wait_sort(1'b1);
    collect(up, DEPTH, 1'b0, 1'b1);
    push_block(dn, 0);
    wait_sort(1'b1);
    collect(up, DEPTH, 1'b0, 1'b1);
  endtask

  task automatic test_stalls();
    blk_t v, e;
    v = '{32'd40, 32'd10, 32'd70, 32'd30, 32'd10, 32'd99, 32'd0, 32'd55};
    e = '{32'd0, 32'd10, 32'd10, 32'd30, 32'd40, 32'd55, 32'd70, 32'd99};
    push_block(v, 3);
    wait_sort(1'b1);
    collect(e, DEPTH, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midway();
    blk_t v, dn, e;
    v  = '{32'd50, 32'd20, 32'd90, 32'd10, 32'd70, 32'd30, 32'd80, 32'd60};
    dn = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    e  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    // Mid-LOAD: four words in.
    for (int i = 0; i < 4; i++) push(v[i]);
    pulse_reset("rst_load");
    push_block(dn, 0);
    wait_sort(1'b0);
    collect(e, DEPTH, 1'b0, 1'b0);
    // Mid-SORT: after pass 3.
    push_block(v, 0);
    for (int k = 0; k < 4; k++) tick();
    pulse_reset("rst_sort");
    push_block(dn, 0);
    wait_sort(1'b0);
    collect(e, DEPTH, 1'b0, 1'b0);
    // Mid-OUT: after output word 2.
    push_block(v, 0);
    wait_sort(1'b0);
    collect('{32'd10, 32'd20, 32'd30, 32'd50, 32'd60, 32'd70, 32'd80, 32'd90}, 3, 1'b0, 1'b0);
    pulse_reset("rst_out");
    push_block(dn, 0);
    wait_sort(1'b0);
    collect(e, DEPTH, 1'b0, 1'b0);
  endtask

`ifdef STREAM_SORTER_DESC_EN
  task automatic test_desc();
    blk_t v, e;
    v = '{32'd5, 32'd3, 32'd9, 32'd1, 32'd7, 32'd2, 32'd8, 32'd6};
    e = '{32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd3, 32'd2, 32'd1};
    for (int i = 0; i < DEPTH; i++) begin
      desc = (i == 0) ? 1'b1 : 1'(i % 2);
      push(v[i]);
    end
    desc = 1'b0;
    wait_sort(1'b0);
    collect(e, DEPTH, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
`ifdef STREAM_SORTER_DESC_EN
    desc      = 1'b0;
`endif
    test_reset();
    test_basic();
    test_unsigned_dups();
    test_back_to_back();
    test_stalls();
    test_reset_midway();
`ifdef STREAM_SORTER_DESC_EN
    test_desc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_sorter.md
STREAM_SORTER -- requirements
Module: stream_sorter

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each data word.
REQ-002 Parameter DEPTH, default 8: words per sort block; legal range 2..64.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_data holds a word.
REQ-006 in_data  input  WIDTH  unsigned input word.
REQ-007 in_ready  output  1  block can take a word.
REQ-008 out_valid  output  1  out_data holds a sorted word.
REQ-009 out_data  output  WIDTH  sorted output word.
REQ-010 out_last  output  1  marks the final word of a block.
REQ-011 out_ready  input  1  downstream accepts out_data.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, SORT and OUT.
REQ-013 An input beat SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; an output beat SHALL be accepted on a rising edge with out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL be 1 in IDLE and LOAD and 0 in SORT and OUT; out_valid SHALL be 1 only in OUT.
REQ-015 IDLE SHALL go to LOAD on the first accepted beat; the word is stored in buffer slot 0; word n of the block goes to slot n.
REQ-016 On the DEPTH-th accepted beat the state SHALL become SORT; in_valid with in_ready=0 SHALL be ignored without data loss upstream.
REQ-017 SORT SHALL run exactly DEPTH odd-even transposition passes, one per cycle: even passes compare-swap pairs (0,1),(2,3)..., odd passes pairs (1,2),(3,4)...; pass 0 is even.
REQ-018 Comparison SHALL be unsigned over the full WIDTH; equal words SHALL NOT be swapped.
REQ-019 out_valid SHALL rise exactly DEPTH cycles after the edge that accepted the last input beat.
REQ-020 In OUT, out_data SHALL be buffer slot idx (idx starts at 0) and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Each output handshake SHALL advance idx by 1; out_last SHALL equal 1 when idx=DEPTH-1.
REQ-022 The handshake with out_last=1 SHALL return the state to IDLE with in_ready=1 on the next cycle; blocks do not overlap.
REQ-023 Output order SHALL be ascending (slot 0 = minimum) unless REQ-030 selects descending.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, regardless of the current state, including mid-LOAD, mid-SORT and mid-OUT.
REQ-025 While reset is asserted: in_ready=0, out_valid=0, out_data=0, out_last=0, idx and the pass and load counters=0, all buffer slots=0.
REQ-026 in_ready SHALL be 1 on the first cycle after rst_n deasserts; a partial block in progress at reset SHALL be discarded.

Configuration
REQ-027 The macro STREAM_SORTER_DESC_EN SHALL control descending-order support.
REQ-028 With the macro defined, the block SHALL add port desc  input  1  order select.
REQ-029 desc SHALL be sampled on the first accepted beat of each block and held for that block.
REQ-030 With the macro defined and sampled desc=1, the block SHALL swap when the lower slot is less than the upper slot, producing descending output; equal words SHALL NOT be swapped.
REQ-031 Without the macro, the desc port SHALL be absent and the block SHALL be ascending only, with no sampling logic.

Verification (WIDTH=32, DEPTH=8)
REQ-032 Input 5,3,9,1,7,2,8,6, out_ready=1 -> output 1,2,3,5,6,7,8,9, out_last on 9, out_valid rising 8 cycles after the last input edge.
REQ-033 Input 0xFFFFFFFF,0,0x80000000,1,4,4,4,0 -> output 0,0,1,4,4,4,0x80000000,0xFFFFFFFF (unsigned compare, duplicates kept).
REQ-034 Input already sorted 1..8, then reverse-sorted 8..1 back to back -> both blocks output 1..8, in_ready=0 throughout SORT and OUT.
REQ-035 Toggle out_ready randomly and in_valid with gaps -> out_data stable while stalled, no lost or duplicated words, in_ready=0 during SORT and OUT.
REQ-036 Assert rst_n=0 after 4 loaded words, after SORT pass 3, and after output word 2 -> all outputs 0 at once, then a fresh block 8..1 outputs 1..8 correctly.
REQ-037 With STREAM_SORTER_DESC_EN and desc=1 on the first beat, then toggling desc: input 5,3,9,1,7,2,8,6 -> output 9,8,7,6,5,3,2,1.
